muldiv_unit: RTL and testbench

//   Multi-cycle integer multiply/divide unit for the RV32M extension. Companion to the single-cycle ALU in EX.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit_core.sv | 60 ++++++
 rtl/muldiv_unit.sv | 95 +++++++++
 tb/tb_muldiv_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 encodings, FSM states and operand-signedness predicates.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return op == MD_MUL || op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM;
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM;
    endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// muldiv_iter_core: XLEN-step shift-add / restoring-divide datapath on a 2*XLEN accumulator.
// MULDIV_FAST_MUL_EN: multiplies load the full product at start and hold it for the one BUSY step.
module muldiv_iter_core #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_next,
    output logic              last
);

    logic [2*XLEN-1:0] acc, acc_ld, mstep, dstep;
    logic [XLEN-1:0]   b_r;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [CW-1:0]     cnt, cnt_ld;
    logic              div_r, fast;

    // Multiply: hi += b when multiplier lsb set, then shift right. Divide: shift left, trial subtract.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_r} : '0);
    assign mstep    = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff     = rem_sh - {1'b0, b_r};
    assign dstep    = {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]};
    assign acc_next = fast ? acc : div_r ? dstep : mstep;
    assign last     = cnt == '0;

`ifdef MULDIV_FAST_MUL_EN
    assign fast   = !div_r;
    assign acc_ld = div ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    assign cnt_ld = div ? CW'(XLEN - 1) : '0;
`else
    assign fast   = 1'b0;
    assign acc_ld = {{XLEN{1'b0}}, a};
    assign cnt_ld = CW'(XLEN - 1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            b_r   <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= acc_ld;
            b_r   <= b;
            div_r <= div;
            cnt   <= cnt_ld;
        end else if (step) begin
            acc   <= acc_next;
            cnt   <= last ? cnt : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multi-cycle multiply/divide with valid/ready handshake and tag pass-through.
// MULDIV_FAST_MUL_EN selects a single-cycle registered multiplier for MUL* (divide unchanged).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state, state_nx;
    op_e               op_r;
    logic              neg_r, accept, sa, sb, b_zero, ovf, special, last;
    logic [XLEN-1:0]   a_mag, b_mag, sp_val, div_sel, fix;
    logic [2*XLEN-1:0] acc_next, prod_s;

    assign in_ready  = rst_n && !flush && state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign accept    = in_valid && in_ready;
    assign sa        = is_signed_a(in_op) && in_a[XLEN-1];
    assign sb        = is_signed_b(in_op) && in_b[XLEN-1];
    assign a_mag     = sa ? -in_a : in_a;
    assign b_mag     = sb ? -in_b : in_b;
    assign b_zero    = in_b == '0;
    assign ovf       = (in_op == MD_DIV || in_op == MD_REM) && in_a == MIN_INT && &in_b;
    assign special   = is_div(in_op) && (b_zero || ovf);
    // in_op[1] separates REM* from DIV*; the overflow quotient MIN_INT equals in_a
    assign sp_val    = b_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);
    assign prod_s    = neg_r ? -acc_next : acc_next;
    assign div_sel   = op_r[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    assign fix       = is_div(op_r) ? (neg_r ? -div_sel : div_sel)
                     : op_r == MD_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && !special),
        .step     (state == S_BUSY),
        .div      (is_div(in_op)),
        .a        (a_mag),
        .b        (b_mag),
        .acc_next (acc_next),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = accept ? (special ? S_DONE : S_BUSY) : S_IDLE;
            S_BUSY:  state_nx = last ? S_DONE : S_BUSY;
            S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
            op_r       <= MD_MUL;
            neg_r      <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                out_tag <= in_tag;
                op_r    <= op_e'(in_op);
                neg_r   <= (is_div(in_op) && in_op[1]) ? sa : sa ^ sb;
                if (special) out_result <= sp_val;
            end else if (state == S_BUSY && last) begin
                out_result <= fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results, latency, backpressure, flush and reset checks.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0, out_result;
    logic [4:0]  in_tag = '0, out_tag;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic take(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " idle_after_take"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    task automatic op_chk(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int lat);
        int n;
        issue(op, a, b, tag);
        wait_done(n);
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " result"}, 64'(out_result), 64'(exp));
        check({name, " tag"}, 64'(out_tag), 64'(tag));
        take(name);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", 64'(out_result), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        op_chk("MUL 7*-3",       3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT);
        op_chk("MULH min*min",   3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MUL_LAT);
        op_chk("MULHU max*max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, MUL_LAT);
        op_chk("MULHSU -1*max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, MUL_LAT);
        op_chk("MULHU 2^31*2",   3'd3, 32'h80000000, 32'd2,        5'd30, 32'd1,        MUL_LAT);
        op_chk("DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, DIV_LAT);
        op_chk("REM -7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, DIV_LAT);
        op_chk("DIV 7/-2",       3'd4, 32'd7,        32'hFFFFFFFE, 5'd7,  32'hFFFFFFFD, DIV_LAT);
        op_chk("REM 7/-2",       3'd6, 32'd7,        32'hFFFFFFFE, 5'd8,  32'd1,        DIV_LAT);
        op_chk("DIV min/2",      3'd4, 32'h80000000, 32'd2,        5'd9,  32'hC0000000, DIV_LAT);
        op_chk("DIVU 100/7",     3'd5, 32'd100,      32'd7,        5'd10, 32'd14,       DIV_LAT);
        op_chk("REMU 100/7",     3'd7, 32'd100,      32'd7,        5'd11, 32'd2,        DIV_LAT);
        op_chk("DIV 5/0",        3'd4, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1);
        op_chk("REM 5/0",        3'd6, 32'd5,        32'd0,        5'd13, 32'd5,        1);
        op_chk("DIVU 5/0",       3'd5, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        op_chk("REMU 5/0",       3'd7, 32'd5,        32'd0,        5'd15, 32'd5,        1);
        op_chk("DIV min/-1",     3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
        op_chk("REM min/-1",     3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);

        issue(3'd5, 32'd20, 32'd3, 5'd19);
        wait_done(n);
        check("bp latency", 64'(n), 64'(DIV_LAT));
        for (int i = 0; i < 10; i++) begin
            check("bp result", 64'(out_result), 64'd6);
            check("bp tag", 64'(out_tag), 64'd19);
            check("bp busy", {62'd0, out_valid, in_ready}, 64'd2);
            @(negedge clk);
        end
        take("bp");

        issue(3'd5, 32'd100, 32'd7, 5'd20);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush kills out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_op = 3'd5; in_a = 32'd50; in_b = 32'd5; in_tag = 5'd21;
        @(negedge clk);
        check("flush blocks in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n += int'(out_valid);
        end
        check("flush no result", 64'(n), 64'd0);
        op_chk("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 5'd22, 32'd3, DIV_LAT);

        issue(3'd4, 32'd100, 32'd7, 5'd23);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midop reset out_valid", 64'(out_valid), 64'd0);
        check("midop reset out_result", 64'(out_result), 64'd0);
        check("midop reset out_tag", 64'(out_tag), 64'd0);
        check("midop reset in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        op_chk("DIVU 100/7 after reset", 3'd5, 32'd100, 32'd7, 5'd24, 32'd14, DIV_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
